// File: rtl/mul_pkg.sv
// Shared sizing defaults and FSM encoding for the 1024-bit sliced multiplier scheduler.
package mul_pkg;
   localparam int WIDTH_DEF = 1024;
   localparam int SLICE_DEF = 256;
   localparam int LANES_DEF = WIDTH_DEF / SLICE_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/mul1024_scheduler_if.sv
// Operand/product handshake bundle between a requester (master) and the scheduler (slave).
interface mul1024_scheduler_if
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               abort;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   modport master (
      output in_valid, op_a, op_b, abort, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, abort, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/mul_lane_slice.sv
// One multiplier lane: right-shifting shift-add of a WIDTH-bit multiplicand by a SLICE-bit multiplier.
module mul_lane_slice
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   load,
   input  logic                   step,
   input  logic [WIDTH-1:0]       mcand,
   input  logic [SLICE-1:0]       mplier,
   output logic [WIDTH+SLICE-1:0] result
);
   // Low SLICE bits start as the multiplier and are shifted out as product bits shift in.
   logic [WIDTH+SLICE-1:0] p;
   logic [WIDTH:0]         upper_sum;

   assign upper_sum = {1'b0, p[WIDTH+SLICE-1:SLICE]}
                    + (p[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

   always_ff @(posedge clk) begin
      if (!rstn) begin
         p <= '0;
      end else if (load) begin
         p <= {{WIDTH{1'b0}}, mplier};
      end else if (step) begin
         p <= {upper_sum, p[SLICE-1:1]};
      end
   end

   assign result = p;
endmodule

// File: rtl/mul1024_scheduler.sv
// Schedules a WIDTH x WIDTH unsigned multiply over LANES shift-add lanes, then folds lane results.
module mul1024_scheduler
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   mul1024_scheduler_if.slave   bus
);
   localparam int LANES = WIDTH / SLICE;
   localparam int LW    = WIDTH + SLICE;
   localparam int PW    = 2 * WIDTH;
   localparam int CW    = $clog2(SLICE + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg;
   logic [PW-1:0]    acc;
   logic             out_valid_r;
   logic             in_ready_r;
   logic             busy_r;
   logic             lane_load;
   logic             lane_step;
   logic [LW-1:0]    lane_res [LANES];
   logic [PW-1:0]    addend;

   assign lane_load = (state == IDLE) && bus.in_valid;
   assign lane_step = (state == RUN);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mul_lane_slice #(
         .WIDTH (WIDTH),
         .SLICE (SLICE)
      ) u_lane (
         .clk    (clk),
         .rstn   (rstn),
         .load   (lane_load),
         .step   (lane_step),
         .mcand  (a_reg),
         .mplier (bus.op_b[SLICE*i +: SLICE]),
         .result (lane_res[i])
      );
   end

   // In ACC the counter doubles as the lane index; each lane lands at its SLICE*i weight.
   always_comb begin
      addend = '0;
      for (int i = 0; i < LANES; i++) begin
         if (cnt == CW'(i)) addend = PW'(lane_res[i]) << (SLICE * i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         cnt         <= '0;
         a_reg       <= '0;
         acc         <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else if (state != IDLE && bus.abort) begin
         state       <= IDLE;
         cnt         <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg      <= bus.op_a;
                  acc        <= '0;
                  cnt        <= '0;
                  state      <= RUN;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            RUN: begin
               if (cnt == CW'(SLICE - 1)) begin
                  cnt   <= '0;
                  state <= ACC;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ACC: begin
               // One extra ACC cycle after the last lane add lets the sum settle before DONE.
               if (cnt == CW'(LANES)) begin
                  cnt         <= '0;
                  state       <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  acc <= acc + addend;
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.busy      = busy_r;
   assign bus.out_valid = out_valid_r;
   assign bus.product   = out_valid_r ? acc : '0;
endmodule

// File: doc/mul1024_scheduler.md
MUL1024_SCHEDULER -- requirements
Module: mul1024_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, 1024, operand width in bits.
REQ-002 SHALL have parameter SLICE, 256, multiplier-slice width per lane; LANES = WIDTH/SLICE (4).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  scheduler can accept operands.
REQ-007 SHALL have port op_a  input  WIDTH  multiplicand.
REQ-008 SHALL have port op_b  input  WIDTH  multiplier, sliced into LANES SLICE-bit parts.
REQ-009 SHALL have port abort  input  1  cancel the operation in flight.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer takes product.
REQ-012 SHALL have port product  output  2*WIDTH  op_a*op_b, unsigned.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, ACC, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready and capture op_a and op_b into internal registers.
REQ-016 On accept, SHALL clear all lane partial products, load lane i with op_b[SLICE*i+SLICE-1 : SLICE*i], clear step counter, and enter RUN.
REQ-017 In RUN, SHALL step every lane once per cycle (shift-add on one multiplier bit) for exactly SLICE cycles; counter 0..SLICE-1, then enter ACC.
REQ-018 In ACC, SHALL add lane i result (WIDTH+SLICE bits) shifted left by SLICE*i into a 2*WIDTH accumulator, one lane per cycle, i = 0..LANES-1, then enter DONE.
REQ-019 SHALL clear the accumulator on accept; accumulator additions SHALL be modulo 2^(2*WIDTH) (no overflow is possible).
REQ-020 SHALL assert out_valid exactly 1+SLICE+LANES = 261 cycles after the accept edge, in DONE only.
REQ-021 SHALL hold product and out_valid stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, SHALL return to IDLE; in_ready is high in the following cycle (no same-cycle re-accept).
REQ-023 abort high in RUN, ACC or DONE SHALL return to IDLE next edge, deassert out_valid, discard results; abort in IDLE is ignored.
REQ-024 in_valid while busy SHALL be ignored, with no effect on the operation in flight.
REQ-025 product SHALL read 0 outside DONE.

Reset
REQ-026 rstn low at a rising edge SHALL force IDLE, counter 0, accumulator 0, lane registers 0, out_valid 0, in_ready 1 after the edge, busy 0.
REQ-027 Reset SHALL take priority over abort, accept and completion, including mid-RUN and mid-ACC.
REQ-028 The first accept after reset release SHALL be possible on the first edge with rstn high.

Structure
REQ-029 WIDTH/SLICE defaults, LANES, and FSM state encodings SHALL live in shared package mul_pkg.
REQ-030 Each lane SHALL be an instance of sub-module mul_lane_slice (SLICE-bit shift-add core with load/step inputs, WIDTH+SLICE-bit result); LANES instances generated.
REQ-031 The scheduler SHALL contain only FSM, counter, operand registers and accumulator; lanes hold no control state.

Verification
REQ-032 op_a=1, op_b=1, out_ready=1 -> out_valid at cycle 261, product=1, in_ready high at cycle 262.
REQ-033 op_a=op_b=2^1024-1 -> product = 2^2048 - 2^1025 + 1.
REQ-034 op_a=2^1023, op_b=2^1023 -> product=2^2046; op_a=0, op_b=all-ones -> product=0.
REQ-035 out_ready low for 20 cycles after out_valid -> product and out_valid stable; in_valid pulses meanwhile ignored; handoff on first out_ready.
REQ-036 abort at RUN cycle 100 -> IDLE next edge, no out_valid; next op (3 x 5) completes with product=15 at 261 cycles.
REQ-037 rstn low during ACC lane 2 -> all outputs at reset values after edge; fresh op_a=7, op_b=9 yields product=63.
